// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC-driven imem requests feeding a small prefetch FIFO for decode.
// Optional macro FETCH_STATS_EN adds stat_delivered / stat_flushed counters.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
`ifdef FETCH_STATS_EN
    input  logic [31:0] redirect_pc,
    output logic [31:0] stat_delivered,
    output logic [31:0] stat_flushed
`else
    input  logic [31:0] redirect_pc
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_U = (CNT_W + 1)'(DEPTH);

    logic [31:0]      instMem_q [DEPTH];
    logic [31:0]      pcMem_q   [DEPTH];

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      reqPc_q, reqPc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             inflight_q, inflight_d;
    logic             epoch_q, epoch_d;
    logic             reqEpoch_q, reqEpoch_d;

    logic [CNT_W:0]   used;
    logic             push;
    logic             pop;
    logic             notEmpty;

    // Credit counts the in-flight word as occupied so a returning word always has a free slot.
    always_comb begin
        used      = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        notEmpty  = (count_q != '0);
        imem_req  = !reset && !redirect_valid && (used < DEPTH_U);
        imem_addr = pc_q;
        out_valid = notEmpty && !redirect_valid;
        out_inst  = notEmpty ? instMem_q[head_q] : 32'h0;
        out_pc    = notEmpty ? pcMem_q[head_q] : 32'h0;
        pop       = out_valid && out_ready;
        push      = inflight_q && (reqEpoch_q == epoch_q) && !redirect_valid;
    end

    always_comb begin
        pc_d       = pc_q;
        reqPc_d    = reqPc_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = imem_req;
        epoch_d    = epoch_q;
        reqEpoch_d = reqEpoch_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            epoch_d = ~epoch_q;
        end else begin
            if (imem_req) begin
                pc_d       = pc_q + 32'd4;
                reqPc_d    = pc_q;
                reqEpoch_d = epoch_q;
            end
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            reqPc_q    <= RESET_PC;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            inflight_q <= 1'b0;
            epoch_q    <= 1'b0;
            reqEpoch_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            reqPc_q    <= reqPc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= inflight_d;
            epoch_q    <= epoch_d;
            reqEpoch_q <= reqEpoch_d;
        end
    end

    // Storage needs no reset; count_q alone decides which slots are live.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            instMem_q[tail_q] <= imem_rdata;
            pcMem_q[tail_q]   <= reqPc_q;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] delivered_q, delivered_d;
    logic [31:0] flushed_q, flushed_d;

    always_comb begin
        delivered_d = delivered_q + (pop ? 32'd1 : 32'd0);
        flushed_d   = flushed_q;
        if (redirect_valid)
            flushed_d = flushed_q + 32'(count_q) + 32'(inflight_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            delivered_q <= 32'h0;
            flushed_q   <= 32'h0;
        end else begin
            delivered_q <= delivered_d;
            flushed_q   <= flushed_d;
        end
    end

    assign stat_delivered = delivered_q;
    assign stat_flushed   = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0100_0000;
    localparam int          DEPTH    = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_delivered;
    logic [31:0] stat_flushed;
    logic [31:0] obsDelivered;
    logic [31:0] obsFlushed;
`endif

    fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
`ifdef FETCH_STATS_EN
        .redirect_pc    (redirect_pc),
        .stat_delivered (stat_delivered),
        .stat_flushed   (stat_flushed)
`else
        .redirect_pc    (redirect_pc)
`endif
    );

    always #5 clock = ~clock;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: a queue of {inst, pc} plus the fetch PC and one outstanding request.
    logic [63:0] mQ[$];
    logic [31:0] mPc = RESET_PC;
    bit          mInflight = 1'b0;
    logic [31:0] mInflightPc = 32'h0;
    int unsigned mDelivered = 0;
    int unsigned mFlushed = 0;

    logic        prevReq = 1'b0;
    logic [31:0] prevAddr = 32'h0;

    logic        obsReq, obsValid;
    logic [31:0] obsAddr, obsInst, obsPc;
    logic [97:0] obsVec, expVec;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {addr[15:0], ~addr[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // One clock cycle: drive inputs at negedge, sample outputs and model expectations, then advance the model.
    task automatic tick(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic        expReq, expValid, expPop;
        logic [31:0] ePc, eInst;
        @(negedge clock);
        reset          = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        imem_rdata     = (prevReq === 1'b1) ? memWord(prevAddr) : $urandom;
        #1;
        obsReq   = imem_req;
        obsAddr  = imem_addr;
        obsValid = out_valid;
        obsInst  = out_inst;
        obsPc    = out_pc;
`ifdef FETCH_STATS_EN
        obsDelivered = stat_delivered;
        obsFlushed   = stat_flushed;
`endif
        expReq   = !r && !rv && ((mQ.size() + int'(mInflight)) < DEPTH);
        expValid = (mQ.size() != 0) && !rv;
        ePc      = (mQ.size() != 0) ? mQ[0][31:0]  : 32'h0;
        eInst    = (mQ.size() != 0) ? mQ[0][63:32] : 32'h0;
        obsVec   = {obsReq, obsAddr, obsValid, obsInst, obsPc};
        expVec   = {expReq, mPc, expValid, eInst, ePc};
        expPop   = expValid && rdy;
        prevReq  = obsReq;
        prevAddr = obsAddr;
        @(posedge clock);
        if (r) begin
            mQ.delete();
            mPc        = RESET_PC;
            mInflight  = 1'b0;
            mDelivered = 0;
            mFlushed   = 0;
        end else if (rv) begin
            mFlushed  += mQ.size() + int'(mInflight);
            mQ.delete();
            mInflight  = 1'b0;
            mPc        = {rpc[31:2], 2'b00};
        end else begin
            if (expPop) begin
                void'(mQ.pop_front());
                mDelivered++;
            end
            if (mInflight) mQ.push_back({memWord(mInflightPc), mInflightPc});
            mInflight = expReq;
            if (expReq) begin
                mInflightPc = mPc;
                mPc         = mPc + 32'd4;
            end
        end
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        testsRun++;
        if (obsVec !== expVec) begin
            testsFailed++;
            $display("[TB] FAIL reset_model: got %h expected %h", obsVec, expVec);
        end
        testsRun++;
        if (obsReq !== 1'b0 || obsValid !== 1'b0 || obsInst !== 32'h0 || obsPc !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got req=%b valid=%b inst=%h pc=%h expected 0,0,0,0",
                     obsReq, obsValid, obsInst, obsPc);
        end
    endtask

    task automatic test_stream();
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 14; k++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            testsRun++;
            if (obsVec !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL stream_model c%0d: got %h expected %h", k, obsVec, expVec);
            end
            if (k == 0) begin
                testsRun++;
                if (obsReq !== 1'b1 || obsAddr !== RESET_PC) begin
                    testsFailed++;
                    $display("[TB] FAIL stream_first_req: got req=%b addr=%h expected 1 %h", obsReq, obsAddr, RESET_PC);
                end
            end else if (k == 1) begin
                testsRun++;
                if (obsValid !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL stream_no_bypass: got valid=%b expected 0", obsValid);
                end
            end else begin
                testsRun++;
                if (obsValid !== 1'b1 || obsPc !== RESET_PC + 32'(4 * (k - 2))) begin
                    testsFailed++;
                    $display("[TB] FAIL stream_pc c%0d: got valid=%b pc=%h expected 1 %h",
                             k, obsValid, obsPc, RESET_PC + 32'(4 * (k - 2)));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int          reqs;
        logic [31:0] pops[$];
        reqs = 0;
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b0);
            testsRun++;
            if (obsVec !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL stall_model c%0d: got %h expected %h", k, obsVec, expVec);
            end
            if (obsReq === 1'b1) begin
                testsRun++;
                if (obsAddr !== RESET_PC + 32'(4 * reqs)) begin
                    testsFailed++;
                    $display("[TB] FAIL stall_addr: got %h expected %h", obsAddr, RESET_PC + 32'(4 * reqs));
                end
                reqs++;
            end
        end
        testsRun++;
        if (reqs != DEPTH) begin
            testsFailed++;
            $display("[TB] FAIL stall_req_count: got %0d expected %0d", reqs, DEPTH);
        end
        for (int k = 0; k < 16; k++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            testsRun++;
            if (obsVec !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL drain_model c%0d: got %h expected %h", k, obsVec, expVec);
            end
            if (obsValid === 1'b1) pops.push_back(obsPc);
        end
        testsRun++;
        if (pops.size() < 5) begin
            testsFailed++;
            $display("[TB] FAIL drain_count: got %0d pops expected at least 5", pops.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                testsRun++;
                if (pops[i] !== RESET_PC + 32'(4 * i)) begin
                    testsFailed++;
                    $display("[TB] FAIL drain_order %0d: got %h expected %h", i, pops[i], RESET_PC + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_redirect();
        bit   seenFirst;
        logic [31:0] target;
        target    = 32'h0100_0100;
        seenFirst = 1'b0;
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b1, target, 1'b1);
        testsRun++;
        if (obsVec !== expVec || obsValid !== 1'b0 || obsReq !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL redirect_cycle: got %h expected %h", obsVec, expVec);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        testsRun++;
        if (obsReq !== 1'b1 || obsAddr !== target) begin
            testsFailed++;
            $display("[TB] FAIL redirect_target_req: got req=%b addr=%h expected 1 %h", obsReq, obsAddr, target);
        end
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            if (obsValid === 1'b1 && !seenFirst) begin
                seenFirst = 1'b1;
                testsRun++;
                if (obsPc !== target) begin
                    testsFailed++;
                    $display("[TB] FAIL redirect_first_pc: got %h expected %h", obsPc, target);
                end
            end
            if (obsValid === 1'b1 && obsPc < target) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL redirect_stale_pc: got %h expected >= %h", obsPc, target);
            end
        end
        testsRun++;
        if (!seenFirst) begin
            testsFailed++;
            $display("[TB] FAIL redirect_no_output: got none expected %h", target);
        end
    endtask

    task automatic test_misaligned_back_to_back();
        logic [31:0] pops[$];
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b1, 32'h0100_0103, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        testsRun++;
        if (obsReq !== 1'b1 || obsAddr !== 32'h0100_0100) begin
            testsFailed++;
            $display("[TB] FAIL misaligned_addr: got req=%b addr=%h expected 1 01000100", obsReq, obsAddr);
        end
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        tick(1'b0, 1'b1, 32'h0000_0300, 1'b1);
        testsRun++;
        if (obsReq !== 1'b0 || obsValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_second_cycle: got req=%b valid=%b expected 0 0", obsReq, obsValid);
        end
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            testsRun++;
            if (obsVec !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL b2b_model c%0d: got %h expected %h", k, obsVec, expVec);
            end
            if (obsValid === 1'b1) pops.push_back(obsPc);
        end
        testsRun++;
        if (pops.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_no_output: got none expected 00000300");
        end
        for (int i = 0; i < pops.size(); i++) begin
            testsRun++;
            if (pops[i] !== 32'h0000_0300 + 32'(4 * i)) begin
                testsFailed++;
                $display("[TB] FAIL b2b_pc %0d: got %h expected %h", i, pops[i], 32'h0000_0300 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_reset_flush();
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b1, 1'b1, 32'h0000_5000, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        testsRun++;
        if (obsValid !== 1'b0 || obsReq !== 1'b1 || obsAddr !== RESET_PC) begin
            testsFailed++;
            $display("[TB] FAIL reset_flush: got valid=%b req=%b addr=%h expected 0 1 %h",
                     obsValid, obsReq, obsAddr, RESET_PC);
        end
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats();
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 12; k++) tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b1, 32'h0100_0400, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        testsRun++;
        if (obsDelivered !== 32'd10 || obsFlushed !== 32'd4) begin
            testsFailed++;
            $display("[TB] FAIL stats_directed: got delivered=%0d flushed=%0d expected 10 4", obsDelivered, obsFlushed);
        end
    endtask
`endif

    task automatic test_random();
        logic r, rv, rdy;
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 600; k++) begin
            r   = ($urandom_range(0, 99) == 0);
            rv  = ($urandom_range(0, 99) < 6);
            rdy = (k < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            tick(r, rv, $urandom, rdy);
            testsRun++;
            if (obsVec !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL random_model c%0d: got %h expected %h", k, obsVec, expVec);
            end
        end
`ifdef FETCH_STATS_EN
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        testsRun++;
        if (obsDelivered !== 32'(mDelivered) || obsFlushed !== 32'(mFlushed)) begin
            testsFailed++;
            $display("[TB] FAIL random_stats: got %0d %0d expected %0d %0d",
                     obsDelivered, obsFlushed, mDelivered, mFlushed);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned_back_to_back();
        test_reset_flush();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
